// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the instruction/data port arbiter and the bus wrapper.
// The access size constants are the same ones the bus wrapper uses.
package sram_like_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } arbState_e;

endpackage

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between instruction fetch and the data (MEM) port.
// One transaction in flight; data wins unless instruction fetch has waited STARVE_LIMIT grants.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_stall,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arbState_e  state, stateNext;
    logic [3:0] starveCnt, starveCntNext;
    logic       instOwns, dataOwns;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            starveCnt <= '0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveCntNext;
        end
    end

    always_comb begin
        stateNext     = state;
        starveCntNext = starveCnt;
        case (state)
            IDLE: begin
                if (data_req && (!inst_req || starveCnt < LIMIT)) begin
                    stateNext = D_ADDR;
                    if (inst_req && starveCnt < LIMIT)
                        starveCntNext = starveCnt + 4'd1;
                end else if (inst_req) begin
                    stateNext     = I_ADDR;
                    starveCntNext = '0;
                end
            end
            // A flush only cancels a request the bus has not yet accepted.
            I_ADDR: begin
                if (bus_addr_ok)    stateNext = I_DATA;
                else if (!inst_req) stateNext = IDLE;
            end
            D_ADDR: begin
                if (bus_addr_ok)    stateNext = D_DATA;
                else if (!data_req) stateNext = IDLE;
            end
            I_DATA:  if (bus_data_ok) stateNext = IDLE;
            D_DATA:  if (bus_data_ok) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Grant mux: bus fields come from the granted side only during the address phase.
    always_comb begin
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_size  = SIZE_BYTE;
        bus_addr  = '0;
        bus_wdata = '0;
        if (state == I_ADDR) begin
            bus_req  = 1'b1;
            bus_size = SIZE_WORD;
            bus_addr = inst_addr;
        end else if (state == D_ADDR) begin
            bus_req   = 1'b1;
            bus_wr    = data_wr;
            bus_size  = data_size;
            bus_addr  = data_addr;
            bus_wdata = data_wdata;
        end
    end

    always_comb begin
        instOwns     = (state == I_ADDR) || (state == I_DATA);
        dataOwns     = (state == D_ADDR) || (state == D_DATA);
        inst_addr_ok = (state == I_ADDR) && bus_addr_ok;
        data_addr_ok = (state == D_ADDR) && bus_addr_ok;
        inst_data_ok = (state == I_DATA) && bus_data_ok;
        data_data_ok = (state == D_DATA) && bus_data_ok;
        inst_rdata   = inst_data_ok ? bus_rdata : '0;
        data_rdata   = data_data_ok ? bus_rdata : '0;
        // Combinational so the stage is released in the data_ok cycle; forced low in reset.
        inst_stall   = !rst && (inst_req || instOwns) && !inst_data_ok;
        data_stall   = !rst && (data_req || dataOwns) && !data_data_ok;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed vector table, hand-written corner sequences,
// and random traffic against a transaction-level reference model.
module tb_sram_like_arbiter;

    localparam int LIMIT = 4;
    localparam logic [31:0] IADDR = 32'hBFC00000;
    localparam logic [31:0] DADDR = 32'h80001000;
    localparam logic [31:0] WDATA = 32'hDEADBEEF;
    localparam logic [31:0] RDATA = 32'h3C080001;

    logic clk = 1'b0, rst = 1'b1;
    logic inst_req = 0, data_req = 0, data_wr = 0;
    logic [1:0] data_size = 0;
    logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, bus_rdata = 0;
    logic bus_addr_ok = 0, bus_data_ok = 0;
    logic inst_addr_ok, inst_data_ok, inst_stall, data_addr_ok, data_data_ok, data_stall;
    logic bus_req, bus_wr;
    logic [1:0] bus_size;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;

    int errors = 0, checks = 0;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .data_stall(data_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busReq, busWr;
        logic [1:0] busSize;
        logic [31:0] busAddr, busWdata;
        logic iAok, iDok, iStall;
        logic [31:0] iRdata;
        logic dAok, dDok, dStall;
        logic [31:0] dRdata;
    } outs_t;

    typedef struct {
        logic r, i, d, a, o;
        logic [7:0] fl;
        logic [31:0] ir;
    } vec_t;

    vec_t tbl[$];

    // Reference model: who owns the port, whether the bus took the address, data grants while inst waits.
    int mOwner = 0;   // 0 none, 1 inst, 2 data
    bit mTaken = 0;
    int mDg = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic i, input logic d, input logic a, input logic o);
        rst = r; inst_req = i; data_req = d; bus_addr_ok = a; bus_data_ok = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addV(input logic r, input logic i, input logic d, input logic a, input logic o,
                        input logic [7:0] fl, input logic [31:0] ir);
        vec_t v;
        v.r = r; v.i = i; v.d = d; v.a = a; v.o = o; v.fl = fl; v.ir = ir;
        tbl.push_back(v);
    endtask

    function automatic logic [7:0] flags();
        return {bus_req, bus_wr, inst_addr_ok, inst_data_ok, inst_stall,
                data_addr_ok, data_data_ok, data_stall};
    endfunction

    function automatic outs_t sampleOut();
        return {bus_req, bus_wr, bus_size, bus_addr, bus_wdata, inst_addr_ok, inst_data_ok,
                inst_stall, inst_rdata, data_addr_ok, data_data_ok, data_stall, data_rdata};
    endfunction

    function automatic outs_t modelOut();
        outs_t e = '0;
        if (rst) return e;
        if (mOwner == 1 && !mTaken) begin
            e.busReq = 1; e.busSize = 2'd2; e.busAddr = inst_addr; e.iAok = bus_addr_ok;
        end
        if (mOwner == 2 && !mTaken) begin
            e.busReq = 1; e.busWr = data_wr; e.busSize = data_size;
            e.busAddr = data_addr; e.busWdata = data_wdata; e.dAok = bus_addr_ok;
        end
        if (mOwner == 1 && mTaken && bus_data_ok) begin e.iDok = 1; e.iRdata = bus_rdata; end
        if (mOwner == 2 && mTaken && bus_data_ok) begin e.dDok = 1; e.dRdata = bus_rdata; end
        e.iStall = (inst_req || mOwner == 1) && !e.iDok;
        e.dStall = (data_req || mOwner == 2) && !e.dDok;
        return e;
    endfunction

    task automatic modelStep();
        if (rst) begin
            mOwner = 0; mTaken = 0; mDg = 0;
        end else if (mOwner == 0) begin
            if (data_req && (!inst_req || mDg < LIMIT)) begin
                mOwner = 2;
                if (inst_req) mDg = (mDg + 1 > LIMIT) ? LIMIT : mDg + 1;
            end else if (inst_req) begin
                mOwner = 1; mDg = 0;
            end
        end else if (!mTaken) begin
            if (bus_addr_ok) mTaken = 1;
            else if ((mOwner == 1) ? !inst_req : !data_req) mOwner = 0;
        end else if (bus_data_ok) begin
            mOwner = 0; mTaken = 0;
        end
    endtask

    initial begin
        inst_addr = IADDR; data_addr = DADDR; data_wdata = WDATA; bus_rdata = RDATA;
        data_wr = 1; data_size = 2'd2;
        // flags: {bus_req, bus_wr, iAok, iDok, iStall, dAok, dDok, dStall}
        addV(1,0,0,0,0, 8'h00, 0);
        // inst fetch alone
        addV(0,1,0,0,0, 8'h08, 0);
        addV(0,1,0,0,0, 8'h88, 0);
        addV(0,1,0,1,0, 8'hA8, 0);
        addV(0,0,0,0,0, 8'h08, 0);
        addV(0,0,0,0,1, 8'h10, RDATA);
        addV(0,0,0,0,0, 8'h00, 0);
        // simultaneous requests: store goes first, then the fetch
        addV(0,1,1,0,0, 8'h09, 0);
        addV(0,1,1,1,0, 8'hCD, 0);
        addV(0,1,0,0,0, 8'h09, 0);
        addV(0,1,0,0,1, 8'h0A, 0);
        addV(0,1,0,0,0, 8'h08, 0);
        addV(0,1,0,1,0, 8'hA8, 0);
        addV(0,0,0,0,1, 8'h10, RDATA);
        addV(0,0,0,0,0, 8'h00, 0);
        // data request withdrawn before the address is taken; stray data_ok in IDLE
        addV(0,0,1,0,0, 8'h01, 0);
        addV(0,0,1,0,0, 8'hC1, 0);
        addV(0,0,0,0,0, 8'hC1, 0);
        addV(0,0,0,0,1, 8'h00, 0);
        addV(0,0,0,0,0, 8'h00, 0);
        // reset while the data transaction is in its data phase
        addV(0,0,1,0,0, 8'h01, 0);
        addV(0,0,1,1,0, 8'hC5, 0);
        addV(0,0,0,0,0, 8'h01, 0);
        addV(1,0,0,0,0, 8'h00, 0);
        addV(0,0,0,0,1, 8'h00, 0);
        addV(0,0,0,0,0, 8'h00, 0);

        tick();
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].r, tbl[k].i, tbl[k].d, tbl[k].a, tbl[k].o);
            #1;
            chk($sformatf("vec%0d_flags", k), 64'(flags()), 64'(tbl[k].fl));
            chk($sformatf("vec%0d_irdata", k), 64'(inst_rdata), 64'(tbl[k].ir));
            if (tbl[k].fl[7] && !tbl[k].fl[6])
                chk($sformatf("vec%0d_iaddr", k), {32'(bus_size), bus_addr}, {32'd2, IADDR});
            if (tbl[k].fl[6])
                chk($sformatf("vec%0d_daddr", k), {30'd0, bus_size, bus_wdata}, {32'd2, WDATA});
            tick();
        end

        // Starvation: both sides saturate the port
        drive(1,0,0,0,0); tick();
        begin
            int grants = 0;
            for (int cyc = 0; cyc < 40 && grants < LIMIT + 2; cyc++) begin
                drive(0,1,1,1,1);
                #1;
                if (bus_req) begin
                    chk($sformatf("starve_grant%0d_is_data", grants), 64'(bus_wr),
                        64'(grants != LIMIT));
                    grants++;
                end
                tick();
            end
            chk("starve_grant_count", 64'(grants), 64'(LIMIT + 2));
        end

        // Fetch flushed after address acceptance still completes before data is granted
        drive(1,0,0,0,0); tick();
        drive(0,1,0,0,0); tick();
        drive(0,1,0,1,0); #1;
        chk("flush_iaok", {31'd0, inst_addr_ok, bus_addr}, {31'd0, 1'b1, IADDR});
        chk("flush_ifields", {62'd0, bus_wr, bus_size != 2'd2}, 64'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0,0,1,0,0); #1;
            chk($sformatf("flush_wait%0d", c),
                {59'd0, bus_req, data_addr_ok, inst_data_ok, inst_stall, data_stall}, 64'h3);
            tick();
        end
        drive(0,0,1,0,1); #1;
        chk("flush_idok", {30'd0, inst_data_ok, inst_stall, inst_rdata}, {30'd0, 2'b10, RDATA});
        tick();
        drive(0,0,1,0,0); #1;
        chk("flush_idle_gap", 64'(bus_req), 64'd0);
        tick();
        #1;
        chk("flush_data_grant", {30'd0, bus_req, bus_wr, bus_addr}, {30'd0, 2'b11, DADDR});
        tick();

        // Random traffic against the model
        drive(1,0,0,0,0); #1;
        modelStep();
        tick();
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 79) == 0);
            inst_req    = ($urandom_range(0, 9) < 6);
            data_req    = ($urandom_range(0, 9) < 6);
            data_wr     = 1'($urandom);
            data_size   = 2'($urandom);
            inst_addr   = $urandom;
            data_addr   = $urandom;
            data_wdata  = $urandom;
            bus_rdata   = $urandom;
            bus_addr_ok = ($urandom_range(0, 9) < 5);
            bus_data_ok = ($urandom_range(0, 9) < 4);
            if (rst) begin mOwner = 0; mTaken = 0; mDg = 0; end
            #1;
            begin
                outs_t e, a;
                e = modelOut();
                a = sampleOut();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL rand%0d: got %h expected %h", n, a, e);
                end
            end
            @(posedge clk);
            modelStep();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
